// File: rtl/alu_seq_if.sv
// alu_seq_if: request/response handshake bundle for the alu_seq sequencer.
//   req_valid/req_ready  request handshake; req_op, req_x, req_y carry the operation
//   rsp_valid/rsp_ready  response handshake; rsp_data, rsp_carry, rsp_zero carry the result
// Modport master is the requester (execute logic), slave is the sequencer.
interface alu_seq_if;
  logic       req_valid;
  logic       req_ready;
  logic [1:0] req_op;
  logic [7:0] req_x;
  logic [7:0] req_y;
  logic       rsp_valid;
  logic       rsp_ready;
  logic [7:0] rsp_data;
  logic       rsp_carry;
  logic       rsp_zero;

  modport master (
    output req_valid, req_op, req_x, req_y, rsp_ready,
    input  req_ready, rsp_valid, rsp_data, rsp_carry, rsp_zero
  );

  modport slave (
    input  req_valid, req_op, req_x, req_y, rsp_ready,
    output req_ready, rsp_valid, rsp_data, rsp_carry, rsp_zero
  );
endinterface

// File: rtl/alu_seq.sv
// alu_seq: multi-cycle sequencer that drives a shared 4-bit ripple adder to
// perform ADD8 / SUB8 / INC8 (two nibble passes) and MUL4 (four shift-add passes).
// Ports:
//   clk, rst           rising-edge clock, synchronous active-high reset
//   bus (slave)        request/response handshake (see alu_seq_if)
//   alu_a, alu_b       adder operands (driven from registered state only)
//   alu_c0             adder carry-in
//   alu_s, alu_c4      adder sum / carry-out, combinational from alu_a/b/c0
module alu_seq (
  input  logic        clk,
  input  logic        rst,
  alu_seq_if.slave    bus,
  output logic [3:0]  alu_a,
  output logic [3:0]  alu_b,
  output logic        alu_c0,
  input  logic [3:0]  alu_s,
  input  logic        alu_c4
);

  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_SUB = 2'b01;
  localparam logic [1:0] OP_MUL = 2'b10;
  localparam logic [1:0] OP_INC = 2'b11;

  typedef enum logic [2:0] {IDLE, LO, HI, MUL, DONE} state_t;

  state_t      state_reg, state_next;
  logic [1:0]  op_reg;
  logic [7:0]  x_reg;
  logic [7:0]  y_reg;
  logic        cy_reg;
  logic [3:0]  a_reg;
  logic [3:0]  q_reg;
  logic [1:0]  cnt_reg;
  logic [3:0]  res_lo_reg;
  logic [7:0]  rsp_data_reg;
  logic        rsp_carry_reg;
  logic        rsp_zero_reg;
  logic        rsp_valid_reg;

  logic [7:0]  hi_result;
  logic [7:0]  mul_next;

  // Operand b for the 8-bit ops: subtraction adds the one's complement
  // (with carry-in 1 on the low nibble), increment adds zero with carry-in 1.
  function automatic logic [3:0] b_sel(input logic [1:0] op, input logic [3:0] yn);
    case (op)
      OP_SUB:  b_sel = ~yn;
      OP_INC:  b_sel = 4'h0;
      default: b_sel = yn;
    endcase
  endfunction

  assign bus.req_ready = (state_reg == IDLE);
  assign bus.rsp_valid = rsp_valid_reg;
  assign bus.rsp_data  = rsp_data_reg;
  assign bus.rsp_carry = rsp_carry_reg;
  assign bus.rsp_zero  = rsp_zero_reg;

  // Full 8-bit result as it will be on the edge that ends the HI pass.
  assign hi_result = {alu_s, res_lo_reg};
  // Shift-add step: {A,Q} <= {c4, sum, Q[3:1]}; after four passes this is x*y.
  assign mul_next  = {alu_c4, alu_s, q_reg[3:1]};

  // Next state and adder drive; all decoded from registered state.
  always_comb begin
    state_next = state_reg;
    alu_a      = 4'h0;
    alu_b      = 4'h0;
    alu_c0     = 1'b0;
    case (state_reg)
      IDLE: begin
        if (bus.req_valid)
          state_next = (bus.req_op == OP_MUL) ? MUL : LO;
      end
      LO: begin
        alu_a      = x_reg[3:0];
        alu_b      = b_sel(op_reg, y_reg[3:0]);
        alu_c0     = (op_reg == OP_SUB) || (op_reg == OP_INC);
        state_next = HI;
      end
      HI: begin
        alu_a      = x_reg[7:4];
        alu_b      = b_sel(op_reg, y_reg[7:4]);
        alu_c0     = cy_reg;
        state_next = DONE;
      end
      MUL: begin
        alu_a  = a_reg;
        alu_b  = q_reg[0] ? x_reg[3:0] : 4'h0;
        alu_c0 = 1'b0;
        if (cnt_reg == 2'd3)
          state_next = DONE;
      end
      DONE: begin
        if (bus.rsp_ready)
          state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg     <= IDLE;
      op_reg        <= OP_ADD;
      x_reg         <= 8'h00;
      y_reg         <= 8'h00;
      cy_reg        <= 1'b0;
      a_reg         <= 4'h0;
      q_reg         <= 4'h0;
      cnt_reg       <= 2'd0;
      res_lo_reg    <= 4'h0;
      rsp_data_reg  <= 8'h00;
      rsp_carry_reg <= 1'b0;
      rsp_zero_reg  <= 1'b0;
      rsp_valid_reg <= 1'b0;
    end else begin
      state_reg <= state_next;
      case (state_reg)
        IDLE: begin
          if (bus.req_valid) begin
            op_reg  <= bus.req_op;
            x_reg   <= bus.req_x;
            y_reg   <= bus.req_y;
            cy_reg  <= 1'b0;
            cnt_reg <= 2'd0;
            a_reg   <= 4'h0;
            q_reg   <= bus.req_y[3:0];
          end
        end
        LO: begin
          res_lo_reg <= alu_s;
          cy_reg     <= alu_c4;
        end
        HI: begin
          rsp_data_reg  <= hi_result;
          rsp_carry_reg <= alu_c4;
          rsp_zero_reg  <= (hi_result == 8'h00);
          rsp_valid_reg <= 1'b1;
        end
        MUL: begin
          a_reg   <= mul_next[7:4];
          q_reg   <= mul_next[3:0];
          cnt_reg <= cnt_reg + 2'd1;
          if (cnt_reg == 2'd3) begin
            rsp_data_reg  <= mul_next;
            rsp_carry_reg <= 1'b0;
            rsp_zero_reg  <= (mul_next == 8'h00);
            rsp_valid_reg <= 1'b1;
          end
        end
        DONE: begin
          if (bus.rsp_ready)
            rsp_valid_reg <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: doc/alu_seq.md
# alu_seq

Multi-cycle arithmetic sequencer that drives the CPU's shared 4-bit ripple adder (`alu`) to perform 8-bit add, subtract and increment, plus a 4x4 unsigned multiply. Each 8-bit operation takes two nibble passes; each multiply takes four shift-add passes. It sits between the instruction/execute logic and the single `alu` instance. It owns the adder's inputs through a valid/ready request/response handshake.

## Interface
- No parameters; widths are fixed by the 4-bit adder.
- `clk`  in  1  rising-edge clock.
- `rst`  in  1  synchronous, active-high reset.
- `req_valid`  in  1  request present.
- `req_ready`  out  1  request accepted on the edge where `req_valid && req_ready`.
- `req_op`  in  2  operation:
  - 00 ADD8 (x+y).
  - 01 SUB8 (x-y).
  - 10 MUL4 (x[3:0]*y[3:0]).
  - 11 INC8 (x+1).
- `req_x`  in  8  operand x.
- `req_y`  in  8  operand y.
- `rsp_valid`  out  1  result available.
- `rsp_ready`  in  1  result consumed on the edge where `rsp_valid && rsp_ready`.
- `rsp_data`  out  8  result.
- `rsp_carry`  out  1  carry out. For SUB8 this is the no-borrow flag (1 iff x>=y). It is 0 for MUL4.
- `rsp_zero`  out  1  1 iff `rsp_data`==0.
- `alu_a`  out  4  adder operand a.
- `alu_b`  out  4  adder operand b.
- `alu_c0`  out  1  adder carry-in.
- `alu_s`  in  4  adder sum (combinational from `alu_a/alu_b/alu_c0`).
- `alu_c4`  in  1  adder carry-out.

## Operation
- States: IDLE, LO, HI, MUL, DONE.
- `req_ready` = (state==IDLE).
- On accept, register op, x, y, clear carry register `cy` and iteration counter `cnt`, then go to:
  - LO for ADD8/SUB8/INC8.
  - MUL for MUL4.
- LO pass: `alu_a`=x[3:0]. `alu_b` and `alu_c0` depend on op:
  - ADD8: `alu_b`=y[3:0], `alu_c0`=0.
  - SUB8: `alu_b`=~y[3:0], `alu_c0`=1.
  - INC8: `alu_b`=0, `alu_c0`=1.
  - At the edge: res[3:0]<=`alu_s`, `cy`<=`alu_c4`, go to HI.
- HI pass: `alu_a`=x[7:4]. `alu_b` is y[7:4], ~y[7:4] or 0, selected per op as in LO. `alu_c0`=`cy`.
  - At the edge: res[7:4]<=`alu_s`, `rsp_carry`<=`alu_c4`, go to DONE.
- MUL pass (shift-add):
  - Registers: A (4b, init 0), Q (4b, init y[3:0]).
  - Drive `alu_a`=A, `alu_b`=Q[0] ? x[3:0] : 0, `alu_c0`=0.
  - At the edge: {A,Q}<={`alu_c4`,`alu_s`,Q[3:1]}, `cnt`<=`cnt`+1.
  - After the 4th pass (`cnt`==3 at the edge): res<={A_next,Q_next}, `rsp_carry`<=0, go to DONE.
- x[7:4] and y[7:4] are ignored for MUL4.
- Entering DONE loads `rsp_data`, `rsp_carry` and `rsp_zero` (computed from the final res) and sets `rsp_valid`=1.
- DONE: outputs are held stable while `rsp_ready`=0. On accept, clear `rsp_valid` and go to IDLE.
- Outside LO/HI/MUL, `alu_a`=0, `alu_b`=0, `alu_c0`=0.
- `req_*` inputs are ignored unless state is IDLE. The block holds no queue: one operation is in flight at a time.

## Timing
- Reset (edge with `rst`=1), priority over all other events:
  - State becomes IDLE.
  - `rsp_valid`=0, `rsp_data`=0x00, `rsp_carry`=0, `rsp_zero`=0.
  - `cy`, A, Q, `cnt` = 0.
  - `req_ready`=1 from the following cycle.
- Reset mid-operation, in any state including DONE: the operation is discarded and no response is produced.
- Latency from the accept edge to `rsp_valid` high:
  - ADD8/SUB8/INC8: 2 cycles.
  - MUL4: 4 cycles.
- Response accept edge: state returns to IDLE, and `req_ready`=1 in the next cycle. A new request can be accepted no earlier than the cycle after the response is accepted.
- Minimum occupancy per operation, assuming `rsp_ready` is held at 1:
  - 8-bit ops: 4 cycles.
  - MUL4: 6 cycles.
- `req_ready` and the `alu_*` outputs are decoded from registered state only.
- The only combinational path through the block is `alu_*` out → `alu_s`/`alu_c4` in → registers. There is no input-to-output combinational path on the handshake ports.
- Arithmetic:
  - All results are modulo 256.
  - MUL4 maximum is 0xF*0xF = 0xE1, so no overflow.

## Test plan
- ADD8 x=0x3A, y=0x4F → `rsp_data`=0x89, carry=0, zero=0. `rsp_valid` rises exactly 2 cycles after accept. The LO cycle shows `alu_a`=0xA, `alu_b`=0xF, `alu_c0`=0.
- ADD8 x=0xFF, y=0x01 → 0x00, carry=1, zero=1. INC8 x=0x0F → 0x10, carry=0 (checks nibble carry propagation through `cy`).
- SUB8 x=0x50, y=0x51 → 0xFF, carry=0. Then SUB8 x=0x51, y=0x51 → 0x00, carry=1, zero=1.
- MUL4 x=0xAF, y=0x3F → 0xE1 (upper nibbles ignored), carry=0, latency 4 cycles. MUL4 x=0x7, y=0x0 → 0x00, zero=1.
- Backpressure: hold `rsp_ready`=0 for 5 cycles after `rsp_valid` with `req_valid`=1 and changing operands → `rsp_*` stable, `req_ready`=0, no second accept. Raise `rsp_ready` → IDLE next cycle, and the pending request is accepted in that cycle.
- Assert `rst` for 1 cycle during the 2nd MUL pass → next cycle `rsp_valid`=0, `rsp_data`=0, `req_ready`=1, `alu_a/b/c0`=0, and no response ever appears for the aborted op.
